packet_deframer: RTL and testbench
==================================

// Module: packet_deframer
// PURPOSE
//  Consumes bytes from serial_rcv (dataout + ready strobe, both on symbclk) and parses frames
//  formatted as: LEN, LEN payload bytes, CHECKSUM. Payload is buffered in a commit/rollback FIFO:
//  it becomes visible downstream only after the checksum matches, and is discarded otherwise.
//  Sits between serial_rcv and the application byte consumer; drains via a valid/ready interface.
// PARAMETERS
//  DATA_WIDTH   8   byte width
//  MAX_LEN      16  largest legal LEN value; legal range is 1..MAX_LEN
//  FIFO_DEPTH   32  payload FIFO entries; power of 2, >= MAX_LEN
// PORTS
//  symbclk      in   1   symbol clock; all logic on posedge
//  reset        in   1   asynchronous, active-high
//  byte_in      in   8   received byte from serial_rcv
//  byte_strobe  in   1   byte_in valid this cycle (one-cycle pulse)
//  out_data     out  8   head-of-FIFO payload byte
//  out_valid    out  1   committed byte available
//  out_ready    in   1   consumer accepts out_data when out_valid & out_ready
//  out_last     out  1   out_data is the final byte of its frame
//  frame_ok     out  1   one-cycle pulse: frame committed
//  frame_err    out  1   one-cycle pulse: frame dropped
//  err_code     out  2   valid with frame_err: 1 = bad LEN, 2 = no room, 3 = checksum mismatch
//  busy         out  1   state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE; wr_ptr, commit_ptr, rd_ptr, cnt, sum = 0; out_valid, out_last, frame_ok,
//    frame_err, busy = 0; err_code = 0. A reset mid-frame discards all uncommitted data.
//  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Each entry stores {last, byte}.
//  - Committed count = commit_ptr - rd_ptr. free = FIFO_DEPTH - (wr_ptr - rd_ptr).
//  - sum is an 8-bit running sum, mod 256, of LEN plus all payload bytes.
//  - IDLE, on strobe: if byte_in == 0 or byte_in > MAX_LEN -> frame_err, code 1, stay IDLE.
//    Else if byte_in > free -> frame_err, code 2, cnt = byte_in + 1, go to SKIP.
//    Else cnt = byte_in, sum = byte_in, go to PAYLOAD.
//  - PAYLOAD, on strobe: write {cnt==1, byte_in} at wr_ptr, wr_ptr++, sum += byte_in, cnt--.
//    When cnt reaches 0, go to CHECK.
//  - CHECK, on strobe: if byte_in == sum -> commit_ptr = wr_ptr and pulse frame_ok.
//    Otherwise wr_ptr = commit_ptr (rollback) and pulse frame_err, code 3. Either way go to IDLE.
//  - SKIP, on strobe: cnt--. At cnt == 1, go to IDLE. No FIFO writes occur in SKIP.
//  - Cycles without byte_strobe never change state, cnt, or sum.
//  - frame_ok and frame_err are registered. They assert in the cycle after the deciding strobe.
//    err_code holds its value until the next frame_err.
//  - A committed frame's bytes become visible through out_valid in the same cycle frame_ok asserts.
//  - Output side: out_valid = (rd_ptr != commit_ptr). out_data and out_last are a
//    combinational read of mem[rd_ptr]. A handshake (out_valid & out_ready) advances rd_ptr.
//    out_ready while out_valid = 0 has no effect.
//  - A read and a write, commit, or rollback in the same cycle are all legal and independent.
//    Rollback never moves wr_ptr below rd_ptr.
//  - Overflow is impossible by construction, because room is reserved at LEN time.
//    The free check counts uncommitted and committed-unread entries.
// TESTING
//  1. Good frame: LEN=03, payload 11 22 33, CHECKSUM=69, out_ready=1
//     -> frame_ok once; bytes 11,22,33 out; out_last only on 33.
//  2. Bad checksum: LEN=02, payload AA BB, CHECKSUM=00
//     -> frame_err, code 3; out_valid stays 0; wr_ptr == commit_ptr.
//  3. Bad LEN: LEN=00, then LEN=MAX_LEN+1 -> two frame_err pulses, code 1; state remains IDLE.
//  4. Backpressure: out_ready=0; two 16-byte good frames (FIFO_DEPTH=32 full), then a third LEN=01
//     -> frame_err, code 2; the following 2 bytes are skipped; a 4th frame is accepted after 1 read.
//  5. Wrap plus concurrency: stream 5 good frames of LEN=13 with out_ready toggling each cycle
//     -> all 65 bytes arrive in order with correct out_last; a handshake coincides with a commit.
//  6. Reset mid-PAYLOAD after 2 of 4 bytes -> all outputs 0, busy 0; the next good frame parses.

Source files
------------

// File: rtl/packet_deframer.sv
// packet_deframer: parses LEN / payload / CHECKSUM frames arriving from serial_rcv and
// releases each payload downstream only after its checksum has been verified.
module packet_deframer #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LEN    = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                  symbclk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] byte_in,
  input  logic                  byte_strobe,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  frame_ok,
  output logic                  frame_err,
  output logic [1:0]            err_code,
  output logic                  busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [DATA_WIDTH-1:0] MAX_LEN_V = DATA_WIDTH'(MAX_LEN);
  localparam logic [DATA_WIDTH-1:0] ONE_V     = DATA_WIDTH'(1);
  localparam logic [PW-1:0]         DEPTH_V   = PW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, SKIP} state_t;

  state_t                state;
  logic [PW-1:0]         wr_ptr, commit_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] cnt, sum;
  logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];

  logic [PW-1:0]         used, free;
  logic [DATA_WIDTH-1:0] free_w;
  logic                  len_bad, wr_en, rd_fire, head_last;
  logic [DATA_WIDTH-1:0] head_data;

  // Room is counted against everything not yet read, including uncommitted bytes
  assign used    = wr_ptr - rd_ptr;
  assign free    = DEPTH_V - used;
  assign free_w  = DATA_WIDTH'(free);
  assign len_bad = (byte_in == '0) || (byte_in > MAX_LEN_V);
  assign wr_en   = (state == PAYLOAD) && byte_strobe;
  assign rd_fire = out_valid && out_ready;

  assign out_valid              = (rd_ptr != commit_ptr);
  assign {head_last, head_data} = mem[rd_ptr[AW-1:0]];
  // Stale storage is masked so idle outputs read as zero
  assign out_data = out_valid ? head_data : '0;
  assign out_last = out_valid & head_last;
  assign busy     = (state != IDLE);

  always_ff @(posedge symbclk) begin
    if (wr_en)
      mem[wr_ptr[AW-1:0]] <= {(cnt == ONE_V), byte_in};
  end

  always_ff @(posedge symbclk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      sum        <= '0;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (rd_fire)
        rd_ptr <= rd_ptr + PW'(1);
      if (byte_strobe) begin
        case (state)
          IDLE: begin
            if (len_bad) begin
              frame_err <= 1'b1;
              err_code  <= 2'd1;
            end else if (byte_in > free_w) begin
              frame_err <= 1'b1;
              err_code  <= 2'd2;
              cnt       <= byte_in + ONE_V;
              state     <= SKIP;
            end else begin
              cnt   <= byte_in;
              sum   <= byte_in;
              state <= PAYLOAD;
            end
          end
          PAYLOAD: begin
            wr_ptr <= wr_ptr + PW'(1);
            sum    <= sum + byte_in;
            cnt    <= cnt - ONE_V;
            if (cnt == ONE_V)
              state <= CHECK;
          end
          CHECK: begin
            if (byte_in == sum) begin
              commit_ptr <= wr_ptr;
              frame_ok   <= 1'b1;
            end else begin
              wr_ptr    <= commit_ptr;
              frame_err <= 1'b1;
              err_code  <= 2'd3;
            end
            state <= IDLE;
          end
          SKIP: begin
            cnt <= cnt - ONE_V;
            if (cnt == ONE_V)
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_packet_deframer.sv
// tb_packet_deframer: directed frames with hand-computed checksums and expected byte streams.
module tb_packet_deframer;

  logic       symbclk = 1'b0;
  logic       reset;
  logic [7:0] byte_in;
  logic       byte_strobe;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  int checks = 0;
  int passes = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  int valid_seen = 0;
  int coincide = 0;
  int ok_base, err_base;
  logic       is_check = 1'b0;
  logic [7:0] pl [16];
  logic [8:0] exp_q [$];
  logic [8:0] got_q [$];

  packet_deframer #(.DATA_WIDTH(8), .MAX_LEN(16), .FIFO_DEPTH(32)) dut (
    .symbclk(symbclk), .reset(reset), .byte_in(byte_in), .byte_strobe(byte_strobe),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .busy(busy)
  );

  always #5 symbclk = ~symbclk;

  // Observe on the falling edge; inputs only change just after rising edges
  always @(negedge symbclk) begin
    if (!reset) begin
      if (out_valid && out_ready) got_q.push_back({out_last, out_data});
      if (frame_ok) ok_cnt++;
      if (frame_err) err_cnt++;
      if (out_valid) valid_seen++;
      if (is_check && byte_strobe && out_valid && out_ready) coincide++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    byte_in = b;
    byte_strobe = 1'b1;
    @(posedge symbclk);
    #1;
    byte_strobe = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge symbclk);
      #1;
    end
  endtask

  task automatic fillPayload(input logic [7:0] base);
    for (int i = 0; i < 16; i++) pl[i] = base + 8'(i);
  endtask

  function automatic logic [7:0] modelSum(input logic [7:0] len);
    logic [7:0] s = len;
    for (int i = 0; i < int'(len); i++) s = s + pl[i];
    return s;
  endfunction

  task automatic sendFrame(input logic [7:0] len, input logic [7:0] chk, input bit expect_ok);
    applyStimulus(len);
    for (int i = 0; i < int'(len); i++) applyStimulus(pl[i]);
    is_check = 1'b1;
    applyStimulus(chk);
    is_check = 1'b0;
    if (expect_ok)
      for (int i = 0; i < int'(len); i++) exp_q.push_back({(i == int'(len) - 1), pl[i]});
  endtask

  task automatic compareQueues(input string tag);
    int n;
    checkOutput({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b1;
    byte_in = 8'h00;
    byte_strobe = 1'b0;
    out_ready = 1'b0;
    #1;
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_out_last", out_last, 1'b0);
    checkOutput("rst_frame_ok", frame_ok, 1'b0);
    checkOutput("rst_frame_err", frame_err, 1'b0);
    checkOutput("rst_err_code", err_code, 2'd0);
    checkOutput("rst_busy", busy, 1'b0);
    idle(2);
    reset = 1'b0;
    idle(1);

    $display("[TB] good frame");
    out_ready = 1'b1;
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    sendFrame(8'h03, 8'h69, 1'b1);
    checkOutput("t1_frame_ok", frame_ok, 1'b1);
    checkOutput("t1_frame_err", frame_err, 1'b0);
    idle(5);
    checkOutput("t1_ok_pulses", ok_cnt, 1);
    checkOutput("t1_drained", out_valid, 1'b0);
    compareQueues("t1");

    $display("[TB] bad checksum");
    valid_seen = 0;
    pl[0] = 8'hAA; pl[1] = 8'hBB;
    sendFrame(8'h02, 8'h00, 1'b0);
    checkOutput("t2_frame_err", frame_err, 1'b1);
    checkOutput("t2_err_code", err_code, 2'd3);
    checkOutput("t2_frame_ok", frame_ok, 1'b0);
    idle(3);
    checkOutput("t2_valid_seen", valid_seen, 0);
    checkOutput("t2_busy", busy, 1'b0);

    $display("[TB] bad LEN");
    err_base = err_cnt;
    applyStimulus(8'h00);
    checkOutput("t3_err_zero", frame_err, 1'b1);
    checkOutput("t3_code_zero", err_code, 2'd1);
    checkOutput("t3_busy_zero", busy, 1'b0);
    applyStimulus(8'h11);
    checkOutput("t3_err_big", frame_err, 1'b1);
    checkOutput("t3_code_big", err_code, 2'd1);
    checkOutput("t3_busy_big", busy, 1'b0);
    idle(2);
    checkOutput("t3_err_pulses", err_cnt - err_base, 2);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    ok_base = ok_cnt;
    fillPayload(8'h80);
    sendFrame(8'h10, modelSum(8'h10), 1'b1);
    checkOutput("t4_ok_a", frame_ok, 1'b1);
    fillPayload(8'hC0);
    sendFrame(8'h10, modelSum(8'h10), 1'b1);
    checkOutput("t4_ok_b", frame_ok, 1'b1);
    err_base = err_cnt;
    applyStimulus(8'h01);
    checkOutput("t4_err_room", frame_err, 1'b1);
    checkOutput("t4_code_room", err_code, 2'd2);
    checkOutput("t4_busy_skip", busy, 1'b1);
    applyStimulus(8'h55);
    checkOutput("t4_busy_skip1", busy, 1'b1);
    applyStimulus(8'h56);
    checkOutput("t4_busy_skip2", busy, 1'b0);
    idle(1);
    checkOutput("t4_err_pulses", err_cnt - err_base, 1);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    pl[0] = 8'h77;
    sendFrame(8'h01, 8'h78, 1'b1);
    checkOutput("t4_ok_fourth", frame_ok, 1'b1);
    out_ready = 1'b1;
    idle(40);
    checkOutput("t4_ok_pulses", ok_cnt - ok_base, 3);
    compareQueues("t4");

    $display("[TB] wrap and concurrency");
    ok_base = ok_cnt;
    coincide = 0;
    out_ready = 1'b0;
    fork
      begin
        for (int f = 0; f < 5; f++) begin
          fillPayload(8'(f * 16));
          sendFrame(8'd13, modelSum(8'd13), 1'b1);
          idle(6);
        end
      end
      begin
        repeat (140) begin
          @(posedge symbclk);
          #1;
          out_ready = ~out_ready;
        end
      end
    join
    out_ready = 1'b1;
    idle(40);
    checkOutput("t5_ok_pulses", ok_cnt - ok_base, 5);
    checkOutput("t5_coincide", 32'(coincide > 0), 1);
    compareQueues("t5");

    $display("[TB] reset mid-payload");
    fillPayload(8'h41);
    applyStimulus(8'h04);
    applyStimulus(pl[0]);
    applyStimulus(pl[1]);
    checkOutput("t6_busy_before", busy, 1'b1);
    reset = 1'b1;
    #1;
    checkOutput("t6_out_valid", out_valid, 1'b0);
    checkOutput("t6_out_data", out_data, 8'h00);
    checkOutput("t6_out_last", out_last, 1'b0);
    checkOutput("t6_frame_ok", frame_ok, 1'b0);
    checkOutput("t6_frame_err", frame_err, 1'b0);
    checkOutput("t6_err_code", err_code, 2'd0);
    checkOutput("t6_busy", busy, 1'b0);
    idle(2);
    reset = 1'b0;
    got_q.delete();
    exp_q.delete();
    ok_base = ok_cnt;
    pl[0] = 8'h31; pl[1] = 8'h32;
    sendFrame(8'h02, 8'h65, 1'b1);
    checkOutput("t6_ok_after", frame_ok, 1'b1);
    idle(5);
    checkOutput("t6_ok_pulses", ok_cnt - ok_base, 1);
    compareQueues("t6");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
